// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller for the in-order CPU.
// Produces per-pipeline-register stall/flush from memory waits, branch events,
// load-use interlocks and interrupt drain/entry sequencing. Register index 0 is
// IF/ID and NUM_STAGES-1 is MEM/WB. Flush dominates stall at the same index.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES  = 4,
   parameter int REG_AW      = 4,
   parameter int LOAD_LAT    = 1,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_AW-1:0]     id_rs1,
   input  logic [REG_AW-1:0]     id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [REG_AW-1:0]     ex_rd,
   input  logic                  ex_is_load,
   input  logic                  ex_reg_wr,
   input  logic                  branch_miss,
   input  logic                  branch_id,
   input  logic                  alert,
   input  logic                  int_mask,
   input  logic                  mem_req,
   input  logic                  mem_valid,
   input  logic                  err_clr,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] flush,
   output logic                  int_ack,
   output logic                  mem_timeout_err,
   output logic [1:0]            state
);

   localparam int TW = $clog2(MEM_TIMEOUT) + 1;
   localparam int DW = $clog2(NUM_STAGES) + 1;
   localparam int LW = $clog2(LOAD_LAT) + 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(MEM_TIMEOUT - 1);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(NUM_STAGES - 2);
   localparam logic [LW-1:0] LU_INIT    = LW'(LOAD_LAT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, MEM_WAIT = 2'd1, INT_DRAIN = 2'd2, INT_ENTER = 2'd3} state_t;

   state_t          st_q;
   logic [TW-1:0]   tmo_cnt;
   logic [DW-1:0]   drain_cnt;
   logic [LW-1:0]   lu_cnt;
   logic            int_pend;
   logic            err_q;

   logic mem_stall, lu_cond, lu_hz, normal, tmo_hit, int_req;
   logic [NUM_STAGES-1:0] st_raw, fl;

   assign mem_stall = mem_req & ~mem_valid;
   assign lu_cond   = ex_is_load & ex_reg_wr &
                      ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
   assign lu_hz     = (lu_cnt != '0) | lu_cond;
   assign normal    = (st_q == IDLE) | (st_q == MEM_WAIT);
   assign tmo_hit   = (st_q == MEM_WAIT) & ~mem_valid & (tmo_cnt == TMO_LAST);
   assign int_req   = alert & ~int_mask;

   assign state           = st_q;
   assign mem_timeout_err = err_q;

   // Combinational stall/flush/ack; held at zero while reset is asserted.
   always_comb begin
      st_raw  = '0;
      fl      = '0;
      int_ack = 1'b0;
      if (mem_stall) begin
         st_raw[NUM_STAGES-2:0] = '1;
         fl[NUM_STAGES-1]       = 1'b1;
      end
      // Timeout aborts the stuck memory op by bubbling the EX/MEM register.
      if (tmo_hit) fl[NUM_STAGES-2] = 1'b1;
      case (st_q)
         IDLE, MEM_WAIT: begin
            if (!mem_stall) begin
               if (branch_miss) fl[1:0] = 2'b11;
               else if (lu_hz) begin
                  st_raw[0] = 1'b1;
                  fl[1]     = 1'b1;
               end else if (branch_id) fl[0] = 1'b1;
            end
         end
         INT_DRAIN: begin
            fl[0] = 1'b1;
            if (branch_miss) fl[1] = 1'b1;
         end
         default: begin
            int_ack = 1'b1;
            fl[0]   = 1'b1;
         end
      endcase
      if (!rst_n) begin
         st_raw  = '0;
         fl      = '0;
         int_ack = 1'b0;
      end
      stall = st_raw & ~fl;
      flush = fl;
   end

   // FSM, sequencing counters, pending interrupt and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= IDLE;
         tmo_cnt   <= '0;
         drain_cnt <= '0;
         lu_cnt    <= '0;
         int_pend  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         // Load-use bubbles freeze with the pipeline during a mem stall and
         // are dropped when the instruction is flushed away.
         if (!mem_stall) begin
            if (!normal || branch_miss) lu_cnt <= '0;
            else if (lu_cnt != '0)      lu_cnt <= lu_cnt - LW'(1);
            else if (lu_cond)           lu_cnt <= LU_INIT;
         end
         if (tmo_hit)      err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
         case (st_q)
            IDLE: begin
               if (mem_stall) begin
                  st_q    <= MEM_WAIT;
                  tmo_cnt <= '0;
                  if (int_req) int_pend <= 1'b1;
               end else if (int_pend || int_req) begin
                  st_q      <= INT_DRAIN;
                  drain_cnt <= '0;
               end
            end
            MEM_WAIT: begin
               if (alert) int_pend <= 1'b1;
               if (mem_valid)                st_q <= IDLE;
               else if (tmo_cnt == TMO_LAST) st_q <= IDLE;
               else                          tmo_cnt <= tmo_cnt + TW'(1);
            end
            INT_DRAIN: begin
               if (!mem_stall) begin
                  if (drain_cnt == DRAIN_LAST) st_q <= INT_ENTER;
                  else                         drain_cnt <= drain_cnt + DW'(1);
               end
            end
            default: begin
               st_q     <= IDLE;
               int_pend <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int N  = 4;
   localparam int AW = 4;
   localparam int LL = 2;
   localparam int MT = 15;

   logic clk = 1'b0, rst_n = 1'b0;
   logic [AW-1:0] id_rs1, id_rs2, ex_rd;
   logic id_rs1_used, id_rs2_used, ex_is_load, ex_reg_wr, branch_miss, branch_id;
   logic alert, int_mask, mem_req, mem_valid, err_clr;
   logic [N-1:0] stall, flush;
   logic int_ack, mem_timeout_err;
   logic [1:0] state;

   pipe_hazard_ctrl #(.NUM_STAGES(N), .REG_AW(AW), .LOAD_LAT(LL), .MEM_TIMEOUT(MT)) dut (
      .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_reg_wr(ex_reg_wr),
      .branch_miss(branch_miss), .branch_id(branch_id), .alert(alert), .int_mask(int_mask),
      .mem_req(mem_req), .mem_valid(mem_valid), .err_clr(err_clr), .stall(stall), .flush(flush),
      .int_ack(int_ack), .mem_timeout_err(mem_timeout_err), .state(state));

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;

   // Behavioural model: mode 0 run, 1 waiting on memory, 2 draining, 3 entering handler.
   int m_mode, m_waited, m_drained, m_owed;
   bit m_pend, m_err;
   logic [N-1:0] e_stall, e_flush;
   logic e_ack;
   logic [N-1:0] o_stall, o_flush;
   logic o_ack, o_err;
   logic [1:0] o_state;

   function automatic bit hazard();
      return ex_is_load && ex_reg_wr &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
   endfunction

   function automatic bit mem_blocked();
      return mem_req && !mem_valid;
   endfunction

   function automatic bit timed_out();
      return m_mode == 1 && !mem_valid && m_waited == MT - 1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_waited = 0; m_drained = 0; m_owed = 0; m_pend = 0; m_err = 0;
   endtask

   task automatic model_out();
      bit ms;
      ms = mem_blocked();
      e_stall = '0; e_flush = '0; e_ack = 1'b0;
      if (ms) begin
         e_stall = {1'b0, {(N-1){1'b1}}};
         e_flush[N-1] = 1'b1;
      end
      if (timed_out()) e_flush[N-2] = 1'b1;
      if (m_mode <= 1 && !ms) begin
         if (branch_miss) begin e_flush[0] = 1'b1; e_flush[1] = 1'b1; end
         else if (m_owed > 0 || hazard()) begin e_stall[0] = 1'b1; e_flush[1] = 1'b1; end
         else if (branch_id) e_flush[0] = 1'b1;
      end
      if (m_mode == 2) begin
         e_flush[0] = 1'b1;
         if (branch_miss) e_flush[1] = 1'b1;
      end
      if (m_mode == 3) begin e_ack = 1'b1; e_flush[0] = 1'b1; end
      e_stall = e_stall & ~e_flush;
   endtask

   task automatic model_adv();
      bit ms, tmo;
      ms = mem_blocked();
      tmo = timed_out();
      if (!ms) begin
         if (m_mode >= 2 || branch_miss) m_owed = 0;
         else if (m_owed > 0) m_owed--;
         else if (hazard()) m_owed = LL - 1;
      end
      if (tmo) m_err = 1;
      else if (err_clr) m_err = 0;
      case (m_mode)
         0: if (ms) begin
               m_mode = 1; m_waited = 0;
               if (alert && !int_mask) m_pend = 1;
            end else if (m_pend || (alert && !int_mask)) begin
               m_mode = 2; m_drained = 0;
            end
         1: begin
               if (alert) m_pend = 1;
               if (mem_valid || tmo) m_mode = 0;
               else m_waited++;
            end
         2: if (!ms) begin
               m_drained++;
               if (m_drained == N - 1) m_mode = 3;
            end
         default: begin m_mode = 0; m_pend = 0; end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: compare at the falling edge, advance the model, settle after the rising edge.
   task automatic do_cycle();
      @(negedge clk);
      model_out();
      o_stall = stall; o_flush = flush; o_ack = int_ack; o_state = state; o_err = mem_timeout_err;
      chk("stall", 32'(stall), 32'(e_stall));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("int_ack", 32'(int_ack), 32'(e_ack));
      chk("state", 32'(state), 32'(m_mode));
      chk("timeout_err", 32'(mem_timeout_err), 32'(m_err));
      model_adv();
      @(posedge clk); #1;
   endtask

   task automatic clr_in();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_rs1_used = 0; id_rs2_used = 0;
      ex_is_load = 0; ex_reg_wr = 0; branch_miss = 0; branch_id = 0;
      alert = 0; int_mask = 0; mem_req = 0; mem_valid = 0; err_clr = 0;
   endtask

   // Asynchronous reset with current inputs left in place; outputs must clear at once.
   task automatic pulse_reset(input string tag);
      rst_n = 1'b0;
      #2;
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_flush"}, 32'(flush), 32'd0);
      chk({tag, "_state"}, 32'(state), 32'd0);
      chk({tag, "_err"}, 32'(mem_timeout_err), 32'd0);
      chk({tag, "_ack"}, 32'(int_ack), 32'd0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      clr_in();
      model_reset();
      @(posedge clk); #1;
      pulse_reset("reset");

      // Load-use on rs2, two bubble cycles then release.
      ex_is_load = 1; ex_reg_wr = 1; ex_rd = 4'd5; id_rs2 = 4'd5; id_rs2_used = 1; id_rs1 = 4'd3;
      do_cycle();
      chk("lu_c1_stall", 32'(o_stall), 32'h1); chk("lu_c1_flush", 32'(o_flush), 32'h2);
      ex_is_load = 0;
      do_cycle();
      chk("lu_c2_stall", 32'(o_stall), 32'h1); chk("lu_c2_flush", 32'(o_flush), 32'h2);
      do_cycle();
      chk("lu_c3_stall", 32'(o_stall), 32'h0); chk("lu_c3_flush", 32'(o_flush), 32'h0);
      clr_in();

      // Memory wait for three cycles, then data returns.
      mem_req = 1;
      for (int i = 0; i < 3; i++) begin
         do_cycle();
         chk("mw_stall", 32'(o_stall), 32'h7); chk("mw_flush", 32'(o_flush), 32'h8);
         chk("mw_state", 32'(o_state), (i == 0) ? 32'd0 : 32'd1);
      end
      mem_valid = 1;
      do_cycle();
      chk("mw_done_stall", 32'(o_stall), 32'h0);
      clr_in();
      do_cycle();
      chk("mw_idle_state", 32'(o_state), 32'd0);

      // Memory never answers: abort after MT waiting cycles, then clear the flag.
      mem_req = 1;
      for (int i = 0; i < MT + 1; i++) do_cycle();
      chk("tmo_abort_flush", 32'(o_flush), 32'hC);
      chk("tmo_abort_stall", 32'(o_stall), 32'h3);
      mem_req = 0;
      do_cycle();
      chk("tmo_err_set", 32'(o_err), 32'd1); chk("tmo_state", 32'(o_state), 32'd0);
      err_clr = 1;
      do_cycle();
      err_clr = 0;
      do_cycle();
      chk("tmo_err_clr", 32'(o_err), 32'd0);

      // Interrupt: request cycle, three drain cycles, one entry cycle.
      alert = 1;
      do_cycle();
      alert = 0;
      for (int i = 0; i < N - 1; i++) begin
         do_cycle();
         chk("drain_flush", 32'(o_flush), 32'h1); chk("drain_state", 32'(o_state), 32'd2);
      end
      do_cycle();
      chk("enter_ack", 32'(o_ack), 32'd1); chk("enter_state", 32'(o_state), 32'd3);
      do_cycle();
      chk("post_ack", 32'(o_ack), 32'd0); chk("post_state", 32'(o_state), 32'd0);

      // Priority: branch miss over load-use and ID branch; mem stall over everything.
      branch_miss = 1; branch_id = 1; ex_is_load = 1; ex_reg_wr = 1; ex_rd = 4'd0;
      id_rs1 = 4'd0; id_rs1_used = 1;
      do_cycle();
      chk("prio_flush", 32'(o_flush), 32'h3); chk("prio_stall", 32'(o_stall), 32'h0);
      mem_req = 1;
      do_cycle();
      chk("prio_mem_flush", 32'(o_flush), 32'h8); chk("prio_mem_stall", 32'(o_stall), 32'h7);
      clr_in();
      mem_req = 1;
      do_cycle();
      // Reset in the middle of a memory wait with the request still asserted.
      pulse_reset("rst_mid_wait");
      clr_in();
      do_cycle();

      // Randomized traffic; every third segment has memory that never answers.
      for (int seg = 0; seg < 15; seg++) begin
         int vp;
         vp = (seg % 3 == 0) ? 0 : 45;
         for (int c = 0; c < 200; c++) begin
            id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
            ex_rd = AW'($urandom_range(0, 3));
            id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
            ex_is_load = ($urandom_range(0, 99) < 30); ex_reg_wr = ($urandom_range(0, 99) < 80);
            branch_miss = ($urandom_range(0, 99) < 8); branch_id = ($urandom_range(0, 99) < 15);
            alert = ($urandom_range(0, 99) < 5); int_mask = 1'($urandom);
            mem_req = ($urandom_range(0, 99) < 35); mem_valid = ($urandom_range(0, 99) < vp);
            err_clr = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 499) == 0) pulse_reset("rand_reset");
            else do_cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
